cam_clk_gen: RTL and testbench

- Parametrised, runtime-reconfigurable clock generator for the camera path. Derives NUM_CLOCKS divided clocks from refclk, each with its own divide ratio, high time, phase offset and enable.
- Reports a PLL-style `locked` flag once the outputs have been stable for LOCK_CYCLES.
- Sits between the board reference clock and the camera/pixel-capture logic. Configured by the HPS-side control register block through a valid/ready port.

---
 rtl/cam_clk_gen_pkg.sv | 43 ++++
 rtl/cam_clk_div_channel.sv | 53 +++++
 rtl/cam_clk_gen.sv | 136 +++++++++++++
 tb/tb_cam_clk_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_clk_gen_pkg.sv
// Shared types and helpers for the camera clock generator.
package cam_clk_gen_pkg;

  // Field width of the per-channel configuration record.
  localparam int CFG_DIV_W = 8;

  // Largest supported channel count.
  localparam int MAX_CLOCKS = 8;

  // Controller states.
  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_LOCKED = 2'd1,
    ST_APPLY  = 2'd2
  } cam_state_t;

  // One channel's configuration: period, high time, start count, enable.
  typedef struct packed {
    logic [CFG_DIV_W-1:0] div;
    logic [CFG_DIV_W-1:0] high;
    logic [CFG_DIV_W-1:0] phase;
    logic                 en;
  } ch_cfg_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Select-port width needed for the largest supported channel count.
  localparam int SEL_W_MAX = idx_width(MAX_CLOCKS);

  // Power-on configuration: divide by d, roughly half duty, no offset, enabled.
  function automatic ch_cfg_t default_cfg(input int d);
    ch_cfg_t c;
    c.div   = CFG_DIV_W'(d);
    c.high  = CFG_DIV_W'(d / 2);
    c.phase = '0;
    c.en    = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/cam_clk_div_channel.sv
// One divided-clock output: active configuration, cycle counter and a
// registered, glitch-free clock flop driven from the next counter value.
module cam_clk_div_channel
  import cam_clk_gen_pkg::*;
#(
  parameter ch_cfg_t RESET_CFG = default_cfg(2)
) (
  input  logic    refclk,
  input  logic    rst,
  input  logic    load,
  input  ch_cfg_t cfg,
  output logic    outclk
);

  ch_cfg_t              act;
  logic [CFG_DIV_W-1:0] cnt;
  logic [CFG_DIV_W-1:0] cnt_nxt;
  logic                 clk_d;
  ch_cfg_t              eff;

  // Next counter value and the clock level that goes with it; a load
  // restarts the channel from its new phase under its new settings.
  always_comb begin
    eff     = load ? cfg : act;
    cnt_nxt = cnt;
    if (load) begin
      cnt_nxt = cfg.phase;
    end else if (!act.en) begin
      cnt_nxt = act.phase;
    end else if (cnt >= act.div - CFG_DIV_W'(1)) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + CFG_DIV_W'(1);
    end
    clk_d = eff.en && (cnt_nxt < eff.high);
  end

  // Active configuration, counter and output flop.
  always_ff @(posedge refclk) begin
    if (rst) begin
      act    <= RESET_CFG;
      cnt    <= '0;
      outclk <= 1'b0;
    end else begin
      if (load) begin
        act <= cfg;
      end
      cnt    <= cnt_nxt;
      outclk <= clk_d;
    end
  end

endmodule

// File: rtl/cam_clk_gen.sv
// Runtime-reconfigurable divided-clock generator with a lock indicator.
// Configuration writes land in per-channel pending registers; a one-cycle
// APPLY then loads every channel at once so all outputs restart aligned.
module cam_clk_gen
  import cam_clk_gen_pkg::*;
#(
  parameter  int NUM_CLOCKS  = 2,
  parameter  int DIV_W       = CFG_DIV_W,
  parameter  int LOCK_CYCLES = 16,
  parameter  int DEFAULT_DIV = 2,
  localparam int SEL_W       = idx_width(NUM_CLOCKS)
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_high,
  input  logic [DIV_W-1:0]      cfg_phase,
  input  logic                  cfg_en,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  localparam int                SETTLE_W    = idx_width(LOCK_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_CYCLES - 1);
  localparam logic [SEL_W:0]    NUM_CH      = (SEL_W + 1)'(NUM_CLOCKS);
  localparam ch_cfg_t           RESET_CFG   = default_cfg(DEFAULT_DIV);

  cam_state_t          state;
  logic [SETTLE_W-1:0] settle_cnt;
  ch_cfg_t             pending [NUM_CLOCKS];
  ch_cfg_t             req_cfg;
  logic                xfer;
  logic                cfg_ok;
  logic                apply_load;

  assign xfer       = cfg_valid && cfg_ready;
  assign apply_load = (state == ST_APPLY);

  // Request fields gathered into a channel record.
  always_comb begin
    req_cfg.div   = cfg_div;
    req_cfg.high  = cfg_high;
    req_cfg.phase = cfg_phase;
    req_cfg.en    = cfg_en;
  end

  // Legality: period of at least two, both levels non-empty, start count
  // inside the period, and an existing channel.
  always_comb begin
    cfg_ok = (cfg_div >= DIV_W'(2))
          && (cfg_high >= DIV_W'(1))
          && (cfg_high < cfg_div)
          && (cfg_phase < cfg_div)
          && ({1'b0, cfg_sel} < NUM_CH);
  end

  // Controller: settle timing, lock flag, handshake ready and error pulse.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= ST_SETTLE;
      settle_cnt <= '0;
      locked     <= 1'b0;
      cfg_ready  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        ST_APPLY: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
          locked     <= 1'b0;
          cfg_ready  <= 1'b1;
        end
        ST_SETTLE, ST_LOCKED: begin
          if (xfer && cfg_ok) begin
            state      <= ST_APPLY;
            settle_cnt <= '0;
            locked     <= 1'b0;
            cfg_ready  <= 1'b0;
          end else begin
            if (xfer) begin
              cfg_err <= 1'b1;
            end
            cfg_ready <= 1'b1;
            if (state == ST_SETTLE) begin
              if (settle_cnt == SETTLE_LAST) begin
                state  <= ST_LOCKED;
                locked <= 1'b1;
              end else begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
              end
            end
          end
        end
        default: begin
          state      <= ST_SETTLE;
          settle_cnt <= '0;
          locked     <= 1'b0;
          cfg_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Pending registers: an accepted request overwrites only its own channel.
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        pending[i] <= RESET_CFG;
      end
    end else if (xfer && cfg_ok && (state != ST_APPLY)) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        if (cfg_sel == SEL_W'(i)) begin
          pending[i] <= req_cfg;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
    cam_clk_div_channel #(
      .RESET_CFG (RESET_CFG)
    ) u_ch (
      .refclk (refclk),
      .rst    (rst),
      .load   (apply_load),
      .cfg    (pending[i]),
      .outclk (outclk[i])
    );
  end

endmodule

// File: tb/tb_cam_clk_gen.sv
// Bench for cam_clk_gen: a time-based reference model checked every cycle,
// a table of configuration requests, directed corner sequences and a
// randomized phase. Three channels so an out-of-range select is drivable.
module tb_cam_clk_gen;

  localparam int NUM_CLOCKS  = 3;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 16;
  localparam int DEFAULT_DIV = 2;
  localparam int SEL_W       = 2;

  logic                  refclk = 1'b0;
  logic                  rst = 1'b1;
  logic                  cfg_valid = 1'b0;
  logic                  cfg_ready;
  logic [SEL_W-1:0]      cfg_sel = '0;
  logic [DIV_W-1:0]      cfg_div = '0;
  logic [DIV_W-1:0]      cfg_high = '0;
  logic [DIV_W-1:0]      cfg_phase = '0;
  logic                  cfg_en = 1'b0;
  logic                  cfg_err;
  logic [NUM_CLOCKS-1:0] outclk;
  logic                  locked;

  cam_clk_gen #(
    .NUM_CLOCKS  (NUM_CLOCKS),
    .DIV_W       (DIV_W),
    .LOCK_CYCLES (LOCK_CYCLES),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .cfg_en    (cfg_en),
    .cfg_err   (cfg_err),
    .outclk    (outclk),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: channel output is a function of time since the
  // channel was last (re)started; lock is a function of time since the
  // last settle start.
  int a_div [NUM_CLOCKS], a_high [NUM_CLOCKS], a_phase [NUM_CLOCKS];
  bit a_en  [NUM_CLOCKS];
  int p_div [NUM_CLOCKS], p_high [NUM_CLOCKS], p_phase [NUM_CLOCKS];
  bit p_en  [NUM_CLOCKS];
  int t0    [NUM_CLOCKS];
  bit jr    [NUM_CLOCKS];
  int t = 0;
  int s = 0;
  bit m_apply = 0, m_ready = 0, m_err = 0, model_on = 0;

  typedef struct {
    int sel; int div; int high; int phase; bit en; bit exp_err;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0d got=%0h want=%0h", nm, t, act, exp);
  endtask

  function automatic bit legal(input int sel, input int div, input int high, input int phase);
    return (div >= 2) && (high >= 1) && (high <= div - 1) && (phase <= div - 1) && (sel < NUM_CLOCKS);
  endfunction

  function automatic bit exp_out(input int i);
    if (jr[i] && t == t0[i]) return 1'b0;
    if (!a_en[i]) return 1'b0;
    return ((a_phase[i] + t - t0[i]) % a_div[i]) < a_high[i];
  endfunction

  task automatic model_update();
    t++;
    if (rst) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        p_div[i] = DEFAULT_DIV; p_high[i] = DEFAULT_DIV / 2; p_phase[i] = 0; p_en[i] = 1;
        a_div[i] = DEFAULT_DIV; a_high[i] = DEFAULT_DIV / 2; a_phase[i] = 0; a_en[i] = 1;
        t0[i] = t; jr[i] = 1;
      end
      s = t; m_apply = 0; m_ready = 0; m_err = 0; model_on = 1;
    end else begin
      m_err = 0;
      if (m_apply) begin
        for (int i = 0; i < NUM_CLOCKS; i++) begin
          a_div[i] = p_div[i]; a_high[i] = p_high[i]; a_phase[i] = p_phase[i]; a_en[i] = p_en[i];
          t0[i] = t; jr[i] = 0;
        end
        s = t; m_apply = 0; m_ready = 1;
      end else if (cfg_valid && m_ready) begin
        if (legal(int'(cfg_sel), int'(cfg_div), int'(cfg_high), int'(cfg_phase))) begin
          p_div[cfg_sel] = int'(cfg_div); p_high[cfg_sel] = int'(cfg_high);
          p_phase[cfg_sel] = int'(cfg_phase); p_en[cfg_sel] = cfg_en;
          m_apply = 1; m_ready = 0;
        end else begin
          m_err = 1;
        end
      end else begin
        m_ready = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge refclk);
    model_update();
    #1;
    if (model_on) begin
      for (int i = 0; i < NUM_CLOCKS; i++)
        chk($sformatf("outclk%0d", i), 32'(outclk[i]), 32'(exp_out(i)));
      chk("locked", 32'(locked), 32'(!m_apply && (t - s >= LOCK_CYCLES)));
      chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
    end
  endtask

  task automatic cfg_xfer(input int sel, input int div, input int high, input int phase, input bit en);
    cfg_valid = 1'b1;
    cfg_sel   = SEL_W'(sel);
    cfg_div   = DIV_W'(div);
    cfg_high  = DIV_W'(high);
    cfg_phase = DIV_W'(phase);
    cfg_en    = en;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_lock(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (locked === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    vecs[0] = '{sel: 0, div: 1,   high: 1,   phase: 0,   en: 1, exp_err: 1};
    vecs[1] = '{sel: 0, div: 5,   high: 5,   phase: 0,   en: 1, exp_err: 1};
    vecs[2] = '{sel: 0, div: 5,   high: 2,   phase: 5,   en: 1, exp_err: 1};
    vecs[3] = '{sel: 3, div: 4,   high: 2,   phase: 0,   en: 1, exp_err: 1};
    vecs[4] = '{sel: 0, div: 5,   high: 0,   phase: 0,   en: 1, exp_err: 1};
    vecs[5] = '{sel: 0, div: 0,   high: 0,   phase: 0,   en: 1, exp_err: 1};
    vecs[6] = '{sel: 2, div: 3,   high: 1,   phase: 2,   en: 1, exp_err: 0};
    vecs[7] = '{sel: 1, div: 255, high: 254, phase: 254, en: 1, exp_err: 0};

    // Reset release and default waveforms.
    rst = 1'b1;
    step();
    step();
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    rst = 1'b0;
    wait_lock(40, lat);
    chk("first_lock_latency", 32'(lat), 32'd16);
    repeat (4) step();

    // Reconfigure ch0 while locked.
    cfg_xfer(0, 5, 2, 0, 1);
    chk("apply_ready", 32'(cfg_ready), 32'd0);
    chk("apply_locked", 32'(locked), 32'd0);
    step();
    for (int k = 0; k < 10; k++) begin
      chk("div5_pattern", 32'(outclk[0]), 32'((k % 5) < 2));
      if (k < 9) step();
    end
    wait_lock(40, lat);
    chk("div5_relock", 32'(lat), 32'd7);

    // Phase alignment between ch0 and ch1.
    cfg_xfer(0, 4, 2, 0, 1);
    step();
    cfg_xfer(1, 4, 2, 2, 1);
    step();
    for (int k = 0; k < 8; k++) begin
      chk("phase_ch0", 32'(outclk[0]), 32'((k % 4) < 2));
      chk("phase_ch1_inverted", 32'(outclk[1]), 32'(!((k % 4) < 2)));
      step();
    end

    // Table of requests applied while locked.
    foreach (vecs[v]) begin
      wait_lock(40, lat);
      chk("tbl_locked_before", 32'(locked), 32'd1);
      cfg_xfer(vecs[v].sel, vecs[v].div, vecs[v].high, vecs[v].phase, vecs[v].en);
      chk($sformatf("tbl%0d_err", v), 32'(cfg_err), 32'(vecs[v].exp_err));
      step();
      chk($sformatf("tbl%0d_err_clear", v), 32'(cfg_err), 32'd0);
    end

    // Second transfer five cycles into SETTLE restarts the lock count.
    wait_lock(40, lat);
    cfg_xfer(0, 3, 1, 0, 1);
    repeat (5) step();
    cfg_xfer(0, 6, 3, 1, 1);
    wait_lock(40, lat);
    chk("settle_restart_lock", 32'(lat), 32'd17);

    // Reset during APPLY, then during SETTLE.
    cfg_xfer(1, 7, 3, 2, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_apply_outclk", 32'(outclk), 32'd0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_settle_locked", 32'(locked), 32'd0);
    wait_lock(40, lat);
    chk("rst_settle_lock_latency", 32'(lat), 32'd16);

    // Disable ch1; ch0 keeps running.
    cfg_xfer(1, 4, 2, 0, 0);
    step();
    for (int k = 0; k < 12; k++) begin
      chk("ch1_disabled", 32'(outclk[1]), 32'd0);
      step();
    end

    // Randomized requests and occasional resets against the model.
    for (int k = 0; k < 600; k++) begin
      int d;
      rst = ($urandom_range(0, 149) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      d = $urandom_range(0, 9);
      cfg_sel   = SEL_W'($urandom_range(0, 3));
      cfg_div   = DIV_W'(d);
      cfg_high  = DIV_W'($urandom_range(0, d + 1));
      cfg_phase = DIV_W'($urandom_range(0, d));
      cfg_en    = ($urandom_range(0, 4) != 0);
      step();
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
